// File: rtl/spi_frame_slave.sv
// SPI slave front end: oversampled SCLK/SSEL/MOSI, configurable width/mode, full-duplex MISO; SPI_FRAME_CRC8_EN adds a CRC-8 check and CRC_ERR.
// RX_VALID/FRAME_ERR pulse SYNC_STAGES+2 CLK cycles after SSEL rises; no backpressure, every strobe lasts one cycle.
module spi_frame_slave #(
    parameter int FRAME_W     = 136,
    parameter int OP_W        = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    SCLK,
    input  logic                    SSEL,
    input  logic                    MOSI,
    output logic                    MISO,
    input  logic [FRAME_W-1:0]      TX_DATA,
    output logic [FRAME_W-1:0]      RX_FRAME,
    output logic [OP_W-1:0]         RX_OPCODE,
    output logic [FRAME_W-OP_W-1:0] RX_PAYLOAD,
    output logic                    RX_VALID,
    output logic                    FRAME_ERR,
`ifdef SPI_FRAME_CRC8_EN
    output logic                    CRC_ERR,
`endif
    output logic                    BUSY
);

    localparam int               CNT_W           = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL        = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT         = CNT_W'(FRAME_W + 1);
    localparam logic             SCLK_IDLE       = (CPOL != 0);
    localparam logic             SAMPLE_RISE     = (CPOL == CPHA);
    localparam logic             LAUNCH_AT_START = (CPHA == 0);

    typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ssel_d;
    logic [FRAME_W-1:0]     rx_sr;
    logic [FRAME_W-1:0]     tx_sr;
    logic [CNT_W-1:0]       cnt;
    logic                   launched;

    logic sclk_s, ssel_s, mosi_s;
    logic sclk_rise, sclk_fall, ssel_rise, ssel_fall;
    logic sample_edge, launch_edge;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ssel_s      = ssel_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign ssel_rise   = ssel_s & ~ssel_d;
    assign ssel_fall   = ~ssel_s & ssel_d;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign launch_edge = SAMPLE_RISE ? sclk_fall : sclk_rise;

    assign RX_OPCODE   = RX_FRAME[FRAME_W-1 -: OP_W];
    assign RX_PAYLOAD  = RX_FRAME[FRAME_W-OP_W-1:0];

`ifdef SPI_FRAME_CRC8_EN
    // CRC runs over the whole frame; a frame carrying its own CRC leaves a zero remainder.
    logic [7:0] crc;
    logic [7:0] crc_next;
    assign crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ mosi_s) ? 8'h07 : 8'h00);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // SSEL chain clears to "selected" so RESYNC waits for a genuine deselect.
            sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            ssel_sync <= '0;
            mosi_sync <= '0;
            sclk_d    <= SCLK_IDLE;
            ssel_d    <= 1'b0;
            state     <= RESYNC;
            rx_sr     <= '0;
            tx_sr     <= '0;
            cnt       <= '0;
            launched  <= 1'b0;
            MISO      <= 1'b0;
            RX_FRAME  <= '0;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            BUSY      <= 1'b0;
`ifdef SPI_FRAME_CRC8_EN
            crc       <= 8'h00;
            CRC_ERR   <= 1'b0;
`endif
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ssel_d    <= ssel_s;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef SPI_FRAME_CRC8_EN
            CRC_ERR   <= 1'b0;
`endif
            case (state)
                RESYNC: begin
                    if (ssel_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (ssel_fall) begin
                        tx_sr    <= TX_DATA;
                        cnt      <= '0;
                        BUSY     <= 1'b1;
                        launched <= LAUNCH_AT_START;
                        MISO     <= LAUNCH_AT_START ? TX_DATA[FRAME_W-1] : 1'b0;
`ifdef SPI_FRAME_CRC8_EN
                        crc      <= 8'h00;
`endif
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        rx_sr <= {rx_sr[FRAME_W-2:0], mosi_s};
                        if (cnt != CNT_SAT) begin
                            cnt <= cnt + 1'b1;
                        end
`ifdef SPI_FRAME_CRC8_EN
                        if (cnt < CNT_FULL) begin
                            crc <= crc_next;
                        end
`endif
                    end
                    if (launch_edge) begin
                        if (!launched) begin
                            MISO     <= tx_sr[FRAME_W-1];
                            launched <= 1'b1;
                        end else begin
                            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
                            MISO  <= tx_sr[FRAME_W-2];
                        end
                    end
                    // A sample edge in this same cycle is counted before DONE judges the frame.
                    if (ssel_rise) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    BUSY  <= 1'b0;
                    MISO  <= 1'b0;
                    state <= IDLE;
`ifdef SPI_FRAME_CRC8_EN
                    if (cnt == CNT_FULL && crc == 8'h00) begin
                        RX_FRAME <= rx_sr;
                        RX_VALID <= 1'b1;
                    end else begin
                        FRAME_ERR <= 1'b1;
                        CRC_ERR   <= (cnt == CNT_FULL);
                    end
`else
                    if (cnt == CNT_FULL) begin
                        RX_FRAME <= rx_sr;
                        RX_VALID <= 1'b1;
                    end else begin
                        FRAME_ERR <= 1'b1;
                    end
`endif
                end
                default: state <= RESYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: three instances cover mode 0 (u0), CPOL=1/CPHA=1 (u1) and CPOL=0/CPHA=1 (u2).
module tb_spi_frame_slave;

    localparam int FW   = 136;
    localparam int HALF = 100;

    logic          clk;
    logic          reset;
    logic [2:0]    sclk;
    logic          ssel;
    logic          mosi;
    logic [FW-1:0] tx_data;
    logic [2:0]    miso;
    logic [FW-1:0] rx_frame   [3];
    logic [7:0]    rx_opcode  [3];
    logic [FW-9:0] rx_payload [3];
    logic [2:0]    rx_valid;
    logic [2:0]    frame_err;
    logic [2:0]    busy;
`ifdef SPI_FRAME_CRC8_EN
    logic [2:0]    crc_err;
    int            ncrc;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int nv [3];
    int ne [3];
    int viol;
    logic [2:0] prev_strobe;

    int            last_dv, last_de, last_dc, last_lat;
    logic [255:0]  last_mrx;
    logic          busy_mid;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_frame_slave #(
            .FRAME_W(FW), .OP_W(8), .CPOL(g == 1 ? 1 : 0), .CPHA(g == 0 ? 0 : 1), .SYNC_STAGES(2)
        ) u_dut (
            .CLK(clk), .RESET(reset), .SCLK(sclk[g]), .SSEL(ssel), .MOSI(mosi), .MISO(miso[g]),
            .TX_DATA(tx_data), .RX_FRAME(rx_frame[g]), .RX_OPCODE(rx_opcode[g]),
            .RX_PAYLOAD(rx_payload[g]), .RX_VALID(rx_valid[g]), .FRAME_ERR(frame_err[g]),
`ifdef SPI_FRAME_CRC8_EN
            .CRC_ERR(crc_err[g]),
`endif
            .BUSY(busy[g])
        );
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        viol = 0;
        prev_strobe = '0;
`ifdef SPI_FRAME_CRC8_EN
        ncrc = 0;
`endif
        for (int g = 0; g < 3; g++) begin
            nv[g] = 0;
            ne[g] = 0;
        end
    end

    // Strobe counters plus the single-cycle / mutual-exclusion rule.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rx_valid[g]) nv[g] <= nv[g] + 1;
            if (frame_err[g]) ne[g] <= ne[g] + 1;
            if ((rx_valid[g] && frame_err[g]) || ((rx_valid[g] || frame_err[g]) && prev_strobe[g]))
                viol <= viol + 1;
        end
        prev_strobe <= rx_valid | frame_err;
`ifdef SPI_FRAME_CRC8_EN
        if (crc_err[0] && frame_err[0]) ncrc <= ncrc + 1;
`endif
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One SSEL-framed transfer of nbits on instance inst; bits[nbits-1] goes first.
    task automatic spi_frame(input int inst, input int nbits, input logic [255:0] bits,
                             input logic [FW-1:0] tx, input int rst_at);
        logic cpol, cpha;
        int   v0, e0, c0;
        cpol = (inst == 1);
        cpha = (inst != 0);
        v0 = nv[inst];
        e0 = ne[inst];
`ifdef SPI_FRAME_CRC8_EN
        c0 = ncrc;
`else
        c0 = 0;
`endif
        last_mrx = '0;
        busy_mid = 1'b0;
        tx_data = tx;
        ssel = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
            end
            if (i == nbits / 2) begin
                tx_data  = ~tx;
                busy_mid = busy[inst];
            end
            if (!cpha) begin
                mosi = bits[nbits-1-i];
                #(HALF);
                last_mrx[nbits-1-i] = miso[inst];
                sclk[inst] = ~cpol;
                #(HALF);
                sclk[inst] = cpol;
            end else begin
                sclk[inst] = ~cpol;
                mosi = bits[nbits-1-i];
                #(HALF);
                last_mrx[nbits-1-i] = miso[inst];
                sclk[inst] = cpol;
                #(HALF);
            end
        end
        #(HALF);
        @(posedge clk); #1 ssel = 1'b1;
        last_lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (last_lat < 0 && (rx_valid[inst] || frame_err[inst])) last_lat = k;
        end
        @(negedge clk);
        last_dv = nv[inst] - v0;
        last_de = ne[inst] - e0;
`ifdef SPI_FRAME_CRC8_EN
        last_dc = ncrc - c0;
`else
        last_dc = c0;
`endif
        #(HALF);
    endtask

    function automatic logic [7:0] crc8(input logic [127:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0]  bits;
        logic [FW-1:0] good;
        logic [127:0]  data;
        int            e1, e2;
        reset   = 1'b1;
        ssel    = 1'b1;
        mosi    = 1'b0;
        sclk    = 3'b010;
        tx_data = '0;
        good    = '0;
        data    = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_frame", 256'(rx_frame[0]), 256'd0);
        check("reset_flags", 256'({busy[0], miso[0], rx_valid[0], frame_err[0]}), 256'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(posedge clk);

`ifndef SPI_FRAME_CRC8_EN
        // Mode 0 basic decode; u1/u2 see SSEL toggle with no SCLK.
        e1 = ne[1];
        e2 = ne[2];
        bits = 256'({8'd1, 128'd10});
        spi_frame(0, FW, bits, '0, -1);
        check("t1_valid_cnt", 256'(last_dv), 256'd1);
        check("t1_err_cnt", 256'(last_de), 256'd0);
        check("t1_opcode", 256'(rx_opcode[0]), 256'h01);
        check("t1_payload", 256'(rx_payload[0]), 256'd10);
        check("t1_latency", 256'(last_lat), 256'd4);
        check("t1_busy_mid", 256'(busy_mid), 256'd1);
        check("t1_busy_after", 256'({busy[0], miso[0]}), 256'd0);
        check("noclk_err_u1u2", 256'((ne[1] - e1) * 10 + (ne[2] - e2)), 256'd11);

        // Full duplex with random MOSI; TX_DATA flips mid-frame and must be ignored.
        bits = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bits[255:FW] = '0;
        good = bits[FW-1:0];
        spi_frame(0, FW, bits, 136'hA5, -1);
        check("t2_valid_cnt", 256'(last_dv), 256'd1);
        check("t2_miso_stream", 256'(last_mrx[FW-1:0]), 256'(136'hA5));
        check("t2_rx_frame", 256'(rx_frame[0]), 256'(good));

        // Short, long and empty frames.
        bits = '1;
        spi_frame(0, FW - 1, bits, '0, -1);
        check("short_err", 256'(last_de * 10 + last_dv), 256'd10);
        check("short_latency", 256'(last_lat), 256'd4);
        check("short_frame_kept", 256'(rx_frame[0]), 256'(good));
        spi_frame(0, FW + 1, bits, '0, -1);
        check("long_err", 256'(last_de * 10 + last_dv), 256'd10);
        check("long_frame_kept", 256'(rx_frame[0]), 256'(good));
        spi_frame(0, 0, bits, '0, -1);
        check("empty_err", 256'(last_de * 10 + last_dv), 256'd10);

        // CPOL=1/CPHA=1 and CPOL=0/CPHA=1.
        bits = 256'({8'd4, 128'd0});
        spi_frame(1, FW, bits, {8'hC3, 128'h1234}, -1);
        check("m3_valid_cnt", 256'(last_dv * 10 + last_de), 256'd10);
        check("m3_opcode", 256'(rx_opcode[1]), 256'h04);
        check("m3_miso_stream", 256'(last_mrx[FW-1:0]), 256'({8'hC3, 128'h1234}));
        spi_frame(2, FW, bits, {8'h81, 128'h8001}, -1);
        check("m1_valid_cnt", 256'(last_dv * 10 + last_de), 256'd10);
        check("m1_opcode", 256'(rx_opcode[2]), 256'h04);
        check("m1_miso_stream", 256'(last_mrx[FW-1:0]), 256'({8'h81, 128'h8001}));

        // Reset after 60 bits with SSEL held low.
        bits = 256'({8'd3, 128'd77});
        spi_frame(0, FW, bits, '0, 60);
        check("rst_no_strobe", 256'(last_dv * 10 + last_de), 256'd0);
        check("rst_frame_clear", 256'(rx_frame[0]), 256'd0);
        bits = 256'({8'd2, 128'd128});
        spi_frame(0, FW, bits, '0, -1);
        check("post_rst_valid", 256'(last_dv * 10 + last_de), 256'd10);
        check("post_rst_opcode", 256'(rx_opcode[0]), 256'h02);
        check("post_rst_payload", 256'(rx_payload[0]), 256'd128);
`else
        e1 = 0;
        e2 = 0;
        data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        bits = 256'({data, crc8(data)});
        good = bits[FW-1:0];
        spi_frame(0, FW, bits, '0, -1);
        check("crc_good_valid", 256'(last_dv * 10 + last_de), 256'd10);
        check("crc_good_no_crcerr", 256'(last_dc), 256'd0);
        check("crc_good_frame", 256'(rx_frame[0]), 256'(good));
        bits[100] = ~bits[100];
        spi_frame(0, FW, bits, '0, -1);
        check("crc_bad_err", 256'(last_dv * 10 + last_de), 256'd1);
        check("crc_bad_crcerr", 256'(last_dc), 256'd1);
        check("crc_bad_frame_kept", 256'(rx_frame[0] + 256'(e1 + e2)), 256'(good));
`endif

        check("strobe_rules", 256'(viol), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
